line_buf_ctrl: RTL

- Sequencer for the 5x5 line-buffer window (4 BRAM line delays plus 5 pixel shift registers) feeding the median filter.
- Decodes the HDMI RX timing (dv/hs/vs) and drives the shared BRAM address and write enable.
- Tracks the frame position of the newest pixel and flags when the 5x5 window holds 25 real pixels of the current frame.
- Measures the active line length and reports line-length and address errors.

---
 rtl/line_buf_pkg.sv | 21 ++
 rtl/line_buf_ctrl_if.sv | 40 ++++
 rtl/line_buf_ctrl_sync_edge_det.sv | 23 ++
 rtl/line_buf_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/line_buf_pkg.sv
// Shared types and defaults for the 5x5 line-buffer sequencer.
package line_buf_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2,
        HBLANK = 2'd3
    } lb_state_e;

    localparam int KSIZE_DEF  = 5;
    localparam int ADDR_W_DEF = 11;
    localparam int ROW_W_DEF  = 11;

    function automatic int max_line(input int addr_w);
        return 1 << addr_w;
    endfunction

    localparam int MAX_LINE = max_line(ADDR_W_DEF);

endpackage

// File: rtl/line_buf_ctrl_if.sv
// RX timing in, BRAM sequencing and window status out. zero_fill exists only with
// LINE_BUF_BLANK_ZERO_EN defined.
interface line_buf_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int ROW_W  = 11
);
    logic              rx_dv;
    logic              rx_hs;
    logic              rx_vs;
    logic [ADDR_W-1:0] addr;
    logic              line_we;
    logic [ADDR_W-1:0] col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              win_valid;
    logic              frame_start;
    logic [ADDR_W:0]   line_len;
    logic              len_err;
    logic              addr_ovf;
`ifdef LINE_BUF_BLANK_ZERO_EN
    logic              zero_fill;
`endif

    modport master (
        output rx_dv, rx_hs, rx_vs,
        input  addr, line_we, col_cnt, row_cnt, win_valid, frame_start,
               line_len, len_err, addr_ovf
`ifdef LINE_BUF_BLANK_ZERO_EN
        , input zero_fill
`endif
    );

    modport slave (
        input  rx_dv, rx_hs, rx_vs,
        output addr, line_we, col_cnt, row_cnt, win_valid, frame_start,
               line_len, len_err, addr_ovf
`ifdef LINE_BUF_BLANK_ZERO_EN
        , output zero_fill
`endif
    );
endinterface

// File: rtl/line_buf_ctrl_sync_edge_det.sv
// One-cycle history register with combinational rise/fall pulses against the live input.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic q_d;
    logic q_q;

    always_comb q_d = d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_q <= 1'b0;
        else     q_q <= q_d;
    end

    assign q    = q_q;
    assign rise = d & ~q_q;
    assign fall = ~d & q_q;
endmodule

// File: rtl/line_buf_ctrl.sv
// 5x5 line-buffer sequencer: decodes RX dv/hs/vs, drives the shared BRAM address and write
// enable, tracks window position. Optional blank zero-fill via LINE_BUF_BLANK_ZERO_EN.
module line_buf_ctrl
    import line_buf_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int ROW_W  = ROW_W_DEF,
    parameter int KSIZE  = KSIZE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    line_buf_ctrl_if.slave lb
);
    localparam int              MAX_LN   = max_line(ADDR_W);
    localparam logic [ADDR_W:0] MAX_CNT  = (ADDR_W+1)'(MAX_LN);
    localparam logic [ADDR_W-1:0] ADDR_TOP = '1;
    localparam logic [ADDR_W-1:0] K1_COL = ADDR_W'(KSIZE-1);
    localparam logic [ROW_W-1:0]  K1_ROW = ROW_W'(KSIZE-1);

    lb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_base;
    logic [ADDR_W:0]   line_len_q, line_len_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic              line_we_q, line_we_d;
    logic              frame_start_q, frame_start_d;
    logic              len_err_q, len_err_d;
    logic              ovf_q, ovf_d;
    logic              fill, wr, clr;
    logic              rx_dv;
    logic              dv_q, dv_rise, dv_fall;
    logic              hs_q, hs_rise, hs_fall;
    logic              vs_q, vs_rise, vs_fall;
    logic              unused_edges;

    assign rx_dv = lb.rx_dv;

    sync_edge_det u_dv (.clk(clk), .rst(rst), .d(lb.rx_dv), .q(dv_q), .rise(dv_rise), .fall(dv_fall));
    sync_edge_det u_hs (.clk(clk), .rst(rst), .d(lb.rx_hs), .q(hs_q), .rise(hs_rise), .fall(hs_fall));
    sync_edge_det u_vs (.clk(clk), .rst(rst), .d(lb.rx_vs), .q(vs_q), .rise(vs_rise), .fall(vs_fall));

    assign unused_edges = ^{dv_rise, hs_q, hs_fall, vs_q, vs_fall};

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        frame_start_d = 1'b0;
        case (state_q)
            IDLE: ;
            VBLANK: if (rx_dv) begin
                state_d       = ACTIVE;
                row_d         = '0;
                frame_start_d = 1'b1;
            end
            ACTIVE: if (!rx_dv) state_d = HBLANK;
            HBLANK: if (rx_dv) begin
                state_d = ACTIVE;
                if (row_q != '1) row_d = row_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // A new frame wins over a pixel arriving in the same cycle.
        if (vs_rise) begin
            state_d       = VBLANK;
            row_d         = '0;
            frame_start_d = 1'b0;
        end
    end

    always_comb begin
`ifdef LINE_BUF_BLANK_ZERO_EN
        fill = ~rx_dv & ~vs_rise & (state_d == HBLANK) & (row_q < K1_ROW);
`else
        fill = 1'b0;
`endif
        wr       = rx_dv | fill;
        clr      = hs_rise | vs_rise;
        cnt_base = clr ? '0 : cnt_q;
        addr_d   = clr ? '0 : addr_q;
        cnt_d    = cnt_base;
        ovf_d    = ovf_q;
        // cnt is one bit wider than addr so a full 2**ADDR_W line is distinguishable from overflow.
        if (wr) begin
            if (cnt_base >= MAX_CNT) begin
                addr_d = ADDR_TOP;
                if (rx_dv) ovf_d = 1'b1;
            end else begin
                addr_d = cnt_base[ADDR_W-1:0];
                cnt_d  = cnt_base + 1'b1;
            end
        end
        line_we_d  = wr;
        line_len_d = line_len_q;
        len_err_d  = len_err_q;
        if (dv_fall) begin
            line_len_d = cnt_q;
            if ((row_q != '0) && (cnt_q != line_len_q)) len_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            cnt_q         <= '0;
            row_q         <= '0;
            line_we_q     <= 1'b0;
            frame_start_q <= 1'b0;
            line_len_q    <= '0;
            len_err_q     <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            cnt_q         <= cnt_d;
            row_q         <= row_d;
            line_we_q     <= line_we_d;
            frame_start_q <= frame_start_d;
            line_len_q    <= line_len_d;
            len_err_q     <= len_err_d;
            ovf_q         <= ovf_d;
        end
    end

`ifdef LINE_BUF_BLANK_ZERO_EN
    logic zero_fill_q, zero_fill_d;
    always_comb zero_fill_d = fill;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) zero_fill_q <= 1'b0;
        else     zero_fill_q <= zero_fill_d;
    end
    assign lb.zero_fill = zero_fill_q;
`endif

    assign lb.addr        = addr_q;
    assign lb.col_cnt     = addr_q;
    assign lb.row_cnt     = row_q;
    assign lb.line_we     = line_we_q;
    assign lb.frame_start = frame_start_q;
    assign lb.line_len    = line_len_q;
    assign lb.len_err     = len_err_q;
    assign lb.addr_ovf    = ovf_q;
    assign lb.win_valid   = (state_q == ACTIVE) & dv_q & (row_q >= K1_ROW) & (addr_q >= K1_COL);
endmodule
